// File: rtl/sys_mac_pe.sv
// rtl/sys_mac_pe.sv - systolic MAC processing element, OS/WS dataflow, double-buffered accumulators
// Optional saturating accumulate / partial-sum via SYS_MAC_PE_SAT_EN.
module sys_mac_pe #(
  parameter int IN_WIDTH    = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IN_WIDTH-1:0]    in_a,
  input  logic [ACC_WIDTH-1:0]   in_b,
  input  logic [ACC_WIDTH-1:0]   in_d,
  input  logic                   in_dataflow,
  input  logic                   in_propagate,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic                   in_valid,
  output logic [IN_WIDTH-1:0]    out_a,
  output logic [ACC_WIDTH-1:0]   out_b,
  output logic [ACC_WIDTH-1:0]   out_c,
  output logic                   out_dataflow,
  output logic                   out_propagate,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_valid
);

  generate
    if (ACC_WIDTH < 2 * IN_WIDTH) begin : g_bad_width
      $error("sys_mac_pe: ACC_WIDTH must be >= 2*IN_WIDTH");
    end
  endgenerate

  logic signed [ACC_WIDTH-1:0]   r_c1, r_c2, r_b, r_c;
  logic [IN_WIDTH-1:0]           r_a;
  logic                          r_dataflow, r_propagate, r_valid;
  logic [SHIFT_WIDTH-1:0]        r_shift;

  logic [IN_WIDTH-1:0]           w_w;
  logic signed [2*IN_WIDTH-1:0]  w_prod;
  logic signed [ACC_WIDTH-1:0]   w_p;
  logic signed [ACC_WIDTH-1:0]   w_nxt_c1, w_nxt_c2, w_nxt_b, w_nxt_c;

  function automatic logic signed [ACC_WIDTH-1:0] f_add(
    input logic signed [ACC_WIDTH-1:0] x,
    input logic signed [ACC_WIDTH-1:0] y
  );
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(x) + (ACC_WIDTH+1)'(y);
    f_add = s[ACC_WIDTH-1:0];
`ifdef SYS_MAC_PE_SAT_EN
    // Sign of the wide sum disagrees with the truncated sign only on overflow.
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      f_add = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] f_rshift(
    input logic signed [ACC_WIDTH-1:0] x,
    input logic [SHIFT_WIDTH-1:0]      s
  );
    logic signed [ACC_WIDTH:0] t;
    if (s == '0) begin
      f_rshift = x;
    end else if (int'(s) >= ACC_WIDTH) begin
      f_rshift = x[ACC_WIDTH-1] ? '1 : '0;
    end else begin
      t = (ACC_WIDTH+1)'(x) + ((ACC_WIDTH+1)'(1) << (s - SHIFT_WIDTH'(1)));
      f_rshift = ACC_WIDTH'(t >>> s);
    end
  endfunction

  // WS multiplies against whichever buffer is not being reloaded this beat.
  always_comb begin
    w_w = in_b[IN_WIDTH-1:0];
    if (in_dataflow)
      w_w = in_propagate ? r_c2[IN_WIDTH-1:0] : r_c1[IN_WIDTH-1:0];
  end

  assign w_prod = $signed(in_a) * $signed(w_w);
  assign w_p    = ACC_WIDTH'(w_prod);

  always_comb begin
    w_nxt_c1 = r_c1;
    w_nxt_c2 = r_c2;
    w_nxt_b  = in_b;
    w_nxt_c  = r_c;
    if (!in_dataflow) begin
      if (in_propagate) begin
        w_nxt_c  = f_rshift(r_c1, in_shift);
        w_nxt_c1 = in_d;
        w_nxt_c2 = f_add(r_c2, w_p);
      end else begin
        w_nxt_c  = f_rshift(r_c2, in_shift);
        w_nxt_c2 = in_d;
        w_nxt_c1 = f_add(r_c1, w_p);
      end
    end else begin
      w_nxt_b = f_add(in_b, w_p);
      if (in_propagate) begin
        w_nxt_c  = r_c1;
        w_nxt_c1 = in_d;
      end else begin
        w_nxt_c  = r_c2;
        w_nxt_c2 = in_d;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_c1        <= '0;
      r_c2        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_dataflow  <= 1'b0;
      r_propagate <= 1'b0;
      r_shift     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_c1        <= w_nxt_c1;
        r_c2        <= w_nxt_c2;
        r_a         <= in_a;
        r_b         <= w_nxt_b;
        r_c         <= w_nxt_c;
        r_dataflow  <= in_dataflow;
        r_propagate <= in_propagate;
        r_shift     <= in_shift;
      end
    end
  end

  assign out_a         = r_a;
  assign out_b         = r_b;
  assign out_c         = r_c;
  assign out_dataflow  = r_dataflow;
  assign out_propagate = r_propagate;
  assign out_shift     = r_shift;
  assign out_valid     = r_valid;

endmodule

// File: tb/tb_sys_mac_pe.sv
// tb/tb_sys_mac_pe.sv - directed scoreboard bench for sys_mac_pe (32-bit and 16-bit accumulator instances)
module tb_sys_mac_pe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0]  in_a = '0;
  logic [31:0] in_b = '0, in_d = '0;
  logic        in_dataflow = 1'b0, in_propagate = 1'b0, in_valid = 1'b0;
  logic [4:0]  in_shift = '0;
  logic [7:0]  out_a;
  logic [31:0] out_b, out_c;
  logic        out_dataflow, out_propagate, out_valid;
  logic [4:0]  out_shift;

  logic [15:0] b16 = '0, d16 = '0;
  logic        v16 = 1'b0;
  logic [7:0]  a16_o;
  logic [15:0] b16_o, c16_o;
  logic        df16_o, pr16_o, v16_o;
  logic [4:0]  sh16_o;

  sys_mac_pe #(.IN_WIDTH(8), .ACC_WIDTH(32), .SHIFT_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .in_a(in_a), .in_b(in_b), .in_d(in_d),
    .in_dataflow(in_dataflow), .in_propagate(in_propagate), .in_shift(in_shift),
    .in_valid(in_valid), .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_dataflow(out_dataflow), .out_propagate(out_propagate),
    .out_shift(out_shift), .out_valid(out_valid)
  );

  sys_mac_pe #(.IN_WIDTH(8), .ACC_WIDTH(16), .SHIFT_WIDTH(5)) dut16 (
    .clock(clock), .reset(reset), .in_a(in_a), .in_b(b16), .in_d(d16),
    .in_dataflow(in_dataflow), .in_propagate(in_propagate), .in_shift(in_shift),
    .in_valid(v16), .out_a(a16_o), .out_b(b16_o), .out_c(c16_o),
    .out_dataflow(df16_o), .out_propagate(pr16_o),
    .out_shift(sh16_o), .out_valid(v16_o)
  );

  typedef struct {
    string       tag;
    int          which;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_v(input string tag, input int which, input int exp);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.exp   = 32'(exp);
    q.push_back(e);
  endtask

  function automatic logic [31:0] obs(input int which);
    case (which)
      0:       return out_c;
      1:       return out_b;
      2:       return {{24{out_a[7]}}, out_a};
      3:       return {31'b0, out_valid};
      4:       return {31'b0, out_propagate};
      5:       return {31'b0, out_dataflow};
      6:       return {27'b0, out_shift};
      7:       return {{16{c16_o[15]}}, c16_o};
      8:       return {31'b0, v16_o};
      9:       return {{16{b16_o[15]}}, b16_o};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.which);
      n_tests++;
      assert (o === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, $signed(o), $signed(e.exp));
      end
    end
  endtask

  task automatic expect_zeros(input string tag);
    for (int i = 0; i <= 9; i++) expect_v(tag, i, 0);
  endtask

  task automatic drive(input int a, input int b, input int d, input int df,
                       input int pr, input int sh, input int v);
    in_a         = 8'(a);
    in_b         = 32'(b);
    in_d         = 32'(d);
    in_dataflow  = (df != 0);
    in_propagate = (pr != 0);
    in_shift     = 5'(sh);
    in_valid     = (v != 0);
  endtask

  task automatic drive16(input int a, input int b, input int d, input int pr, input int sh);
    in_a         = 8'(a);
    b16          = 16'(b);
    d16          = 16'(d);
    in_dataflow  = 1'b0;
    in_propagate = (pr != 0);
    in_shift     = 5'(sh);
    v16          = 1'b1;
    in_valid     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_all();
  endtask

  int ovf_exp;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    expect_zeros("reset_state");
    check_all();
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      drive(3, -4, 0, 0, 0, 0, 1);
      expect_v("os_acc_out_c", 0, 0);
      expect_v("os_out_b_pass", 1, -4);
      expect_v("os_out_a", 2, 3);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 1);
    expect_v("os_drain_c1", 0, -36);
    expect_v("os_out_valid", 3, 1);
    expect_v("os_out_prop", 4, 1);
    tick();

    drive(5, 9, 9, 1, 0, 7, 0);
    expect_v("gap_valid", 3, 0);
    expect_v("gap_out_c_hold", 0, -36);
    expect_v("gap_out_a_hold", 2, 0);
    expect_v("gap_prop_hold", 4, 1);
    expect_v("gap_df_hold", 5, 0);
    expect_v("gap_shift_hold", 6, 0);
    tick();

    drive(0, 0, 37, 0, 1, 0, 1);
    expect_v("rnd_load", 0, 0);
    tick();
    drive(0, 0, -37, 0, 1, 3, 1);
    expect_v("rnd_pos", 0, 5);
    expect_v("rnd_shift_out", 6, 3);
    tick();
    drive(0, 0, 4, 0, 1, 3, 1);
    expect_v("rnd_neg", 0, -5);
    tick();
    drive(0, 0, 0, 0, 1, 3, 1);
    expect_v("rnd_half_up", 0, 1);
    tick();

    drive(0, 0, 7, 1, 1, 0, 1);
    expect_v("ws_preload_c", 0, 0);
    expect_v("ws_df_out", 5, 1);
    tick();
    drive(2, 100, 11, 1, 0, 0, 1);
    expect_v("ws_psum_1", 1, 114);
    expect_v("ws_out_c_1", 0, 0);
    tick();
    drive(2, 100, 22, 1, 0, 0, 1);
    expect_v("ws_psum_2", 1, 114);
    expect_v("ws_out_c_2", 0, 11);
    tick();
    drive(2, 100, 33, 1, 0, 0, 1);
    expect_v("ws_psum_3", 1, 114);
    expect_v("ws_out_c_3", 0, 22);
    tick();
    drive(1, 5, 0, 1, 1, 0, 1);
    expect_v("ws_prop1_uses_c2", 1, 38);
    expect_v("ws_c1_kept", 0, 7);
    tick();

    drive(0, 0, 50, 0, 0, 0, 1);
    expect_v("switch_carry_c2", 0, 33);
    expect_v("switch_df", 5, 0);
    tick();

    drive(1, 1, 10, 0, 0, 0, 1); expect_v("tog_0", 0, 50); tick();
    drive(1, 1, 20, 0, 1, 0, 1); expect_v("tog_1", 0, 1);  tick();
    drive(1, 1, 30, 0, 0, 0, 1); expect_v("tog_2", 0, 11); tick();
    drive(1, 1, 40, 0, 1, 0, 1); expect_v("tog_3", 0, 21); tick();
    drive(0, 0, 0, 0, 0, 0, 1);  expect_v("tog_4", 0, 31); tick();
    drive(0, 0, 0, 0, 1, 0, 1);  expect_v("tog_5", 0, 40); tick();

    drive(0, 0, 77, 0, 0, 0, 1); expect_v("pre_rst_load_c2", 0, 0); tick();
    drive(1, 1, 88, 0, 1, 2, 1); expect_v("pre_rst_load_c1", 0, 0); tick();

    drive(9, 9, 9, 1, 1, 4, 1);
    #3;
    reset = 1'b1;
    #1;
    expect_zeros("async_reset");
    check_all();
    repeat (3) begin
      expect_zeros("reset_held");
      tick();
    end
    reset = 1'b0;

    drive(2, 3, 0, 0, 0, 0, 1);
    expect_v("post_rst_c2_zero", 0, 0);
    expect_v("post_rst_b", 1, 3);
    tick();
    drive(0, 0, 0, 0, 1, 0, 1);
    expect_v("post_rst_c1_from_zero", 0, 6);
    tick();

`ifdef SYS_MAC_PE_SAT_EN
    ovf_exp = 32767;
`else
    ovf_exp = -17407;
`endif
    drive16(0, 0, 32000, 1, 0);  expect_v("ovf_load", 7, 0); expect_v("ovf_valid", 8, 1); tick();
    drive16(127, 127, 0, 0, 0);  expect_v("ovf_acc", 7, 0); expect_v("ovf_b16", 9, 127); tick();
    drive16(0, 0, 32767, 1, 0);  expect_v("ovf_result", 7, ovf_exp); tick();
    drive16(0, 0, -5, 1, 1);     expect_v("rshift_max_no_ovf", 7, 16384); tick();
    drive16(0, 0, 0, 1, 20);     expect_v("rshift_wide_neg", 7, -1); tick();
    v16 = 1'b0;
    expect_v("ovf_gap_valid", 8, 0);
    expect_v("ovf_gap_hold", 7, -1);
    tick();

    n_tests++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
